// File: rtl/ex.sv
// Execute stage of the RV32IM core: single-cycle ALU/branch/jump/MUL, plus an
// iterative radix-2 restoring divider that stalls the pipeline while it runs.
module ex #(
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        reg_wen_o,
  output logic [31:0] jump_addr_o,
  output logic        jump_en_o,
  output logic        hold_flag_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] FUNCT7_M   = 7'b0000001;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
  logic is_mext, is_div;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'h000};
  assign is_mext = (opcode == OPC_OP) && (funct7 == FUNCT7_M);
  assign is_div  = is_mext && funct3[2];

  // 64-bit product; operands sign-extended per funct3 (MULHU unsigned, MULHSU op2 unsigned)
  logic op1_sgn, op2_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
  assign op1_sgn  = (funct3 != 3'b011) && op1_i[XLEN-1];
  assign op2_sgn  = !funct3[1] && op2_i[XLEN-1];
  assign mul_a    = {{XLEN{op1_sgn}}, op1_i};
  assign mul_b    = {{XLEN{op2_sgn}}, op2_i};
  assign mul_full = mul_a * mul_b;

  logic [XLEN-1:0] alu_data, alu_jaddr;
  logic alu_wen, alu_jen, br_taken;

  always_comb begin
    unique case (funct3)
      3'b000:  br_taken = (op1_i == op2_i);
      3'b001:  br_taken = (op1_i != op2_i);
      3'b100:  br_taken = ($signed(op1_i) < $signed(op2_i));
      3'b101:  br_taken = ($signed(op1_i) >= $signed(op2_i));
      3'b110:  br_taken = (op1_i < op2_i);
      3'b111:  br_taken = (op1_i >= op2_i);
      default: br_taken = 1'b0;
    endcase
  end

  // Single-cycle result path
  always_comb begin
    alu_data  = '0;
    alu_wen   = 1'b0;
    alu_jen   = 1'b0;
    alu_jaddr = '0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        alu_wen = reg_wen_i;
        if (is_mext) begin
          if (!funct3[2] && MUL_EN)
            alu_data = (funct3 == 3'b000) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end else begin
          case (funct3)
            3'b000:  alu_data = (opcode == OPC_OP && funct7[5]) ? op1_i - op2_i : op1_i + op2_i;
            3'b001:  alu_data = op1_i << op2_i[4:0];
            3'b010:  alu_data = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            3'b011:  alu_data = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            3'b100:  alu_data = op1_i ^ op2_i;
            3'b101:  alu_data = funct7[5] ? XLEN'($signed(op1_i) >>> op2_i[4:0])
                                          : op1_i >> op2_i[4:0];
            3'b110:  alu_data = op1_i | op2_i;
            default: alu_data = op1_i & op2_i;
          endcase
        end
        if (inst_i == NOP_INST) begin
          alu_wen  = 1'b0;
          alu_data = '0;
        end
      end
      OPC_LUI: begin
        alu_wen  = reg_wen_i;
        alu_data = imm_u;
      end
      OPC_AUIPC: begin
        alu_wen  = reg_wen_i;
        alu_data = inst_addr_i + imm_u;
      end
      OPC_JAL: begin
        alu_wen   = reg_wen_i;
        alu_data  = inst_addr_i + XLEN'(4);
        alu_jen   = 1'b1;
        alu_jaddr = inst_addr_i + imm_j;
      end
      OPC_JALR: begin
        alu_wen   = reg_wen_i;
        alu_data  = inst_addr_i + XLEN'(4);
        alu_jen   = 1'b1;
        alu_jaddr = (op1_i + imm_i) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        alu_jen   = br_taken;
        alu_jaddr = br_taken ? inst_addr_i + imm_b : '0;
      end
      default: ;
    endcase
  end

  // Divider datapath: quotient bits shift into div_dvd as the dividend shifts out
  logic [XLEN-1:0] div_dvd, div_dsr, div_rem;
  logic [CW-1:0]   div_cnt;
  logic [RW-1:0]   div_rd;
  logic div_neg_q, div_neg_r, div_sel_rem, div_zero;
  logic div_start_c, div_step_c, div_sgn;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] div_q, div_r, div_res;

  assign div_sgn   = !funct3[0];
  assign div_trial = {div_rem, div_dvd[XLEN-1]} - {1'b0, div_dsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dvd     <= '0;
      div_dsr     <= '0;
      div_rem     <= '0;
      div_cnt     <= '0;
      div_rd      <= '0;
      div_neg_q   <= 1'b0;
      div_neg_r   <= 1'b0;
      div_sel_rem <= 1'b0;
      div_zero    <= 1'b0;
    end else if (div_start_c) begin
      div_dvd     <= (div_sgn && op1_i[XLEN-1]) ? -op1_i : op1_i;
      div_dsr     <= (div_sgn && op2_i[XLEN-1]) ? -op2_i : op2_i;
      div_rem     <= '0;
      div_cnt     <= '0;
      div_rd      <= rd_addr_i;
      div_neg_q   <= div_sgn && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
      div_neg_r   <= div_sgn && op1_i[XLEN-1];
      div_sel_rem <= funct3[1];
      div_zero    <= (op2_i == '0);
    end else if (div_step_c) begin
      div_cnt <= div_cnt + CW'(1);
      if (!div_trial[XLEN]) begin
        div_rem <= div_trial[XLEN-1:0];
        div_dvd <= {div_dvd[XLEN-2:0], 1'b1};
      end else begin
        div_rem <= {div_rem[XLEN-2:0], div_dvd[XLEN-1]};
        div_dvd <= {div_dvd[XLEN-2:0], 1'b0};
      end
    end
  end

  // Overflow (0x80000000 / -1) falls out naturally: magnitude 0x80000000 negates to itself, rem 0
  assign div_q   = div_zero ? '1 : (div_neg_q ? -div_dvd : div_dvd);
  assign div_r   = div_neg_r ? -div_rem : div_rem;
  assign div_res = div_sel_rem ? div_r : div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  logic [RW-1:0]   rd_addr_c;
  logic [XLEN-1:0] rd_data_c, jump_addr_c;
  logic reg_wen_c, jump_en_c, hold_c;

  always_comb begin
    state_nxt   = state;
    div_start_c = 1'b0;
    div_step_c  = 1'b0;
    rd_addr_c   = rd_addr_i;
    rd_data_c   = alu_data;
    reg_wen_c   = alu_wen;
    jump_addr_c = alu_jaddr;
    jump_en_c   = alu_jen;
    hold_c      = 1'b0;
    case (state)
      IDLE: begin
        if (is_div && DIV_EN) begin
          state_nxt   = BUSY;
          div_start_c = 1'b1;
          hold_c      = 1'b1;
          rd_addr_c   = '0;
          rd_data_c   = '0;
          reg_wen_c   = 1'b0;
          jump_addr_c = '0;
          jump_en_c   = 1'b0;
        end
      end
      BUSY: begin
        div_step_c  = 1'b1;
        hold_c      = 1'b1;
        rd_addr_c   = '0;
        rd_data_c   = '0;
        reg_wen_c   = 1'b0;
        jump_addr_c = '0;
        jump_en_c   = 1'b0;
        if (div_cnt == CW'(31)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt   = IDLE;
        rd_addr_c   = div_rd;
        rd_data_c   = div_res;
        reg_wen_c   = 1'b1;
        jump_addr_c = '0;
        jump_en_c   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces every output low immediately, independent of the combinational path
  assign rd_addr_o   = rst ? '0 : rd_addr_c;
  assign rd_data_o   = rst ? '0 : rd_data_c;
  assign reg_wen_o   = !rst && reg_wen_c;
  assign jump_addr_o = rst ? '0 : jump_addr_c;
  assign jump_en_o   = !rst && jump_en_c;
  assign hold_flag_o = !rst && hold_c;

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: per-cycle behavioural model comparison plus
// hand-computed directed checks.
module tb_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic        reg_wen_o, jump_en_o, hold_flag_o;

  always #5 clk = ~clk;

  ex dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_wen_o(reg_wen_o),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o), .hold_flag_o(hold_flag_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        wen;
    logic [4:0]  rd;
    logic        jen;
    logic [31:0] jaddr;
    logic        hold;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic bit is_div(input logic [31:0] ins);
    return ins[6:0] == 7'h33 && ins[31:25] == 7'h01 && ins[14];
  endfunction

  // Reference divide from plain integer arithmetic plus the architectural special cases
  function automatic logic [31:0] model_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint q, r;
    bit sgn = !f3[0];
    bit rem = f3[1];
    if (b == 32'h0) return rem ? a : 32'hFFFFFFFF;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'h0 : 32'h80000000;
    if (sgn) begin
      longint x = $signed(a);
      longint y = $signed(b);
      q = x / y;
      r = x % y;
    end else begin
      longint x = longint'(a);
      longint y = longint'(b);
      q = x / y;
      r = x % y;
    end
    return rem ? r[31:0] : q[31:0];
  endfunction

  function automatic exp_t model_sc(input logic [31:0] ins, pc, a, b,
                                    input logic [4:0] rd, input logic wen);
    exp_t e = '0;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] bi = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] ji = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [31:0] ui = {ins[31:12], 12'h000};
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ub = longint'(b);
    logic [63:0] p;
    logic [4:0] sh = b[4:0];
    bit taken;
    e.rd = rd;
    case (opc)
      7'h13, 7'h33: begin
        e.wen = wen;
        if (opc == 7'h33 && f7 == 7'h01) begin
          case (f3)
            3'd0: begin p = sa * sb; e.data = p[31:0]; end
            3'd1: begin p = sa * sb; e.data = p[63:32]; end
            3'd2: begin p = sa * ub; e.data = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; e.data = p[63:32]; end
            default: e.data = 32'h0;
          endcase
        end else begin
          case (f3)
            3'd0: e.data = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
            3'd1: e.data = a << sh;
            3'd2: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: e.data = (a < b) ? 32'd1 : 32'd0;
            3'd4: e.data = a ^ b;
            3'd5: e.data = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: e.data = a | b;
            default: e.data = a & b;
          endcase
        end
        if (ins == 32'h00000013) begin e.wen = 1'b0; e.data = 32'h0; end
      end
      7'h37: begin e.wen = wen; e.data = ui; end
      7'h17: begin e.wen = wen; e.data = pc + ui; end
      7'h6F: begin e.wen = wen; e.data = pc + 32'd4; e.jen = 1'b1; e.jaddr = pc + ji; end
      7'h67: begin e.wen = wen; e.data = pc + 32'd4; e.jen = 1'b1; e.jaddr = (a + ii) & 32'hFFFFFFFE; end
      7'h63: begin
        case (f3)
          3'd0: taken = a == b;
          3'd1: taken = a != b;
          3'd4: taken = $signed(a) < $signed(b);
          3'd5: taken = $signed(a) >= $signed(b);
          3'd6: taken = a < b;
          3'd7: taken = a >= b;
          default: taken = 1'b0;
        endcase
        e.jen   = taken;
        e.jaddr = taken ? pc + bi : 32'h0;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Model of divide progress: cycles since the divide was accepted
  int          m_age = -1;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) m_age <= -1;
    else if (m_age == -1) begin
      if (is_div(inst_i)) begin
        m_age <= 1;
        m_a   <= op1_i;
        m_b   <= op2_i;
        m_f3  <= inst_i[14:12];
        m_rd  <= rd_addr_i;
      end
    end else if (m_age == 33) m_age <= -1;
    else m_age <= m_age + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    e = '0;
    if (rst) e = '0;
    else if (m_age >= 1 && m_age <= 32) e.hold = 1'b1;
    else if (m_age == 33) begin
      e.wen  = 1'b1;
      e.rd   = m_rd;
      e.data = model_div(m_f3, m_a, m_b);
    end else if (is_div(inst_i)) e.hold = 1'b1;
    else e = model_sc(inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i);
    chk("cyc_hold", 32'(hold_flag_o), 32'(e.hold));
    chk("cyc_wen", 32'(reg_wen_o), 32'(e.wen));
    chk("cyc_data", rd_data_o, e.data);
    chk("cyc_jen", 32'(jump_en_o), 32'(e.jen));
    chk("cyc_jaddr", jump_addr_o, e.jaddr);
    if (e.wen) chk("cyc_rd", 32'(rd_addr_o), 32'(e.rd));
  end

  task automatic drive(input logic [31:0] ins, pc, a, b, input logic [4:0] rd, input logic wen);
    @(posedge clk);
    #1;
    inst_i = ins; inst_addr_i = pc; op1_i = a; op2_i = b; rd_addr_i = rd; reg_wen_i = wen;
  endtask

  task automatic run_div(input string name, input logic [31:0] ins, a, b, req);
    drive(ins, 32'h300, a, b, 5'd9, 1'b1);
    #1;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      chk({name, "_hold"}, 32'(hold_flag_o), 32'd1);
      chk({name, "_nowen"}, 32'(reg_wen_o), 32'd0);
    end
    @(posedge clk);
    #2;
    chk({name, "_done_hold"}, 32'(hold_flag_o), 32'd0);
    chk({name, "_done_wen"}, 32'(reg_wen_o), 32'd1);
    chk({name, "_done_rd"}, 32'(rd_addr_o), 32'd9);
    chk({name, "_done_data"}, rd_data_o, req);
    drive(32'h00000013, 32'h304, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    rst = 1'b1;
    inst_i = NOP; inst_addr_i = 32'h0; op1_i = 32'h0; op2_i = 32'h0;
    rd_addr_i = 5'd0; reg_wen_i = 1'b0;
    #2;
    chk("rst_hold", 32'(hold_flag_o), 32'd0);
    chk("rst_wen", 32'(reg_wen_o), 32'd0);
    chk("rst_jen", 32'(jump_en_o), 32'd0);
    chk("rst_data", rd_data_o, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    drive(i_type(12'hFFF, 3'd0, 7'h13), 32'h0, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1);
    #1;
    chk("addi_wen", 32'(reg_wen_o), 32'd1);
    chk("addi_data", rd_data_o, 32'hFFFFFFFF);
    chk("addi_jen", 32'(jump_en_o), 32'd0);

    drive(b_type(13'd16, 3'd0), 32'h100, 32'd7, 32'd7, 5'd0, 1'b0);
    #1;
    chk("beq_jen", 32'(jump_en_o), 32'd1);
    chk("beq_jaddr", jump_addr_o, 32'h110);
    chk("beq_wen", 32'(reg_wen_o), 32'd0);
    drive(b_type(13'd16, 3'd0), 32'h100, 32'd7, 32'd8, 5'd0, 1'b0);
    #1;
    chk("beq_nt_jen", 32'(jump_en_o), 32'd0);

    drive(i_type(12'h000, 3'd0, 7'h67), 32'h40, 32'h2003, 32'h0, 5'd1, 1'b1);
    #1;
    chk("jalr_jaddr", jump_addr_o, 32'h2002);
    chk("jalr_data", rd_data_o, 32'h44);
    chk("jalr_wen", 32'(reg_wen_o), 32'd1);

    drive(32'hFF9FF0EF, 32'h200, 32'h200, 32'h0, 5'd1, 1'b1);
    #1;
    chk("jal_jaddr", jump_addr_o, 32'h1F8);
    chk("jal_data", rd_data_o, 32'h204);

    drive(r_type(7'h01, 3'd3), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1);
    #1 chk("mulhu_data", rd_data_o, 32'hFFFFFFFE);
    drive(r_type(7'h01, 3'd1), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1);
    #1 chk("mulh_data", rd_data_o, 32'h0);
    drive(r_type(7'h01, 3'd0), 32'h0, 32'd6, 32'hFFFFFFFD, 5'd3, 1'b1);
    #1 chk("mul_data", rd_data_o, 32'hFFFFFFEE);

    // Broader coverage checked by the per-cycle model
    drive(r_type(7'h01, 3'd2), 32'h0, 32'hFFFFFFFE, 32'h80000000, 5'd3, 1'b1);
    drive(r_type(7'h01, 3'd1), 32'h0, 32'h80000000, 32'h7FFFFFFF, 5'd3, 1'b1);
    drive(r_type(7'h20, 3'd0), 32'h0, 32'd5, 32'd9, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd1), 32'h0, 32'h1, 32'd35, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd2), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd3), 32'h0, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd4), 32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd3, 1'b1);
    drive(r_type(7'h20, 3'd5), 32'h0, 32'h80000000, 32'd31, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd5), 32'h0, 32'h80000000, 32'd31, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd6), 32'h0, 32'h12300000, 32'h00000456, 5'd3, 1'b1);
    drive(r_type(7'h00, 3'd7), 32'h0, 32'hFF00FF00, 32'h0FF00FF0, 5'd3, 1'b1);
    drive(i_type(12'h404, 3'd5, 7'h13), 32'h0, 32'hF0000000, 32'h00000404, 5'd3, 1'b1);
    drive(32'hABCDE1B7, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1);
    drive(32'h000011B7 ^ 32'h00000020, 32'h1000, 32'h1000, 32'h0, 5'd3, 1'b1);
    drive(b_type(13'h1FF0, 3'd1), 32'h400, 32'd1, 32'd2, 5'd0, 1'b0);
    drive(b_type(13'd8, 3'd4), 32'h400, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    drive(b_type(13'd8, 3'd5), 32'h400, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    drive(b_type(13'd8, 3'd6), 32'h400, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    drive(b_type(13'd8, 3'd7), 32'h400, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    drive(32'h00112023, 32'h400, 32'h100, 32'h55, 5'd0, 1'b0);
    drive(NOP, 32'h404, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 chk("nop_wen", 32'(reg_wen_o), 32'd0);

    run_div("div", r_type(7'h01, 3'd4), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_div("rem", r_type(7'h01, 3'd6), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_div("divu0", r_type(7'h01, 3'd5), 32'd5, 32'd0, 32'hFFFFFFFF);
    run_div("remu0", r_type(7'h01, 3'd7), 32'd5, 32'd0, 32'd5);
    run_div("rem_ovf", r_type(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_div("div_ovf", r_type(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_div("div0_neg", r_type(7'h01, 3'd4), 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF);
    run_div("rem_neg", r_type(7'h01, 3'd6), 32'd7, 32'hFFFFFFFE, 32'd1);

    // Reset in the middle of a divide
    drive(r_type(7'h01, 3'd4), 32'h300, 32'd100, 32'd7, 5'd9, 1'b1);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(hold_flag_o), 32'd0);
    chk("mid_rst_wen", 32'(reg_wen_o), 32'd0);
    chk("mid_rst_data", rd_data_o, 32'h0);
    chk("mid_rst_rd", 32'(rd_addr_o), 32'd0);
    chk("mid_rst_jen", 32'(jump_en_o), 32'd0);
    inst_i = NOP; op1_i = 32'h0; op2_i = 32'h0; rd_addr_i = 5'd0; reg_wen_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_div("divu_post", r_type(7'h01, 3'd5), 32'd100, 32'd7, 32'd14);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
